rs_station: RTL

Parameterised N-entry reservation station, successor to the fixed 4-entry station.
- Accepts one instruction per cycle with two source operands, each either ready with data or waiting on a producer tag.
- Captures waiting operands from a single common-data-bus (CDB) broadcast.
- Issues the oldest entry whose operands are both valid to one execution unit through a valid/ready handshake.
- Sits between rename/dispatch and one functional unit.

---
 rtl/rs_station.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/rs_station.sv
`default_nettype none
// ============================================================================
// Module      : rs_station
// Description : Parameterised N-entry reservation station. Accepts one
//               instruction per cycle with two source operands, captures
//               waiting operands from a single CDB broadcast and issues the
//               oldest fully-ready entry to one functional unit through a
//               valid/ready handshake.
//
// Ports       : clk, rst (sync, active high), flush (sync clear)
//               alloc_*  : dispatch interface (valid/ready, payload, sources)
//               cdb_*    : result broadcast (valid, tag, data)
//               issue_*  : functional-unit interface (valid/ready, payload)
//               count    : number of occupied entries
//
// Options     : RS_FAST_WAKEUP_EN - when defined, an entry whose last missing
//               operand is on the CDB this cycle may issue in the same cycle
//               with the operand forwarded from cdb_data.
//
// Revision    : 1.0 - initial parameterised release
// ============================================================================
module rs_station #(
    parameter int ENTRIES = 4,
    parameter int INSTR_W = 16,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 128,
    parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    input  logic [INSTR_W-1:0] alloc_instr,
    input  logic [TAG_W-1:0]   alloc_tag,
    input  logic [TAG_W-1:0]   src0_tag,
    input  logic [TAG_W-1:0]   src1_tag,
    input  logic               src0_rdy,
    input  logic               src1_rdy,
    input  logic [DATA_W-1:0]  src0_data,
    input  logic [DATA_W-1:0]  src1_data,
    input  logic               cdb_valid,
    input  logic [TAG_W-1:0]   cdb_tag,
    input  logic [DATA_W-1:0]  cdb_data,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [INSTR_W-1:0] issue_instr,
    output logic [TAG_W-1:0]   issue_tag,
    output logic [DATA_W-1:0]  issue_d0,
    output logic [DATA_W-1:0]  issue_d1,
    output logic [CNT_W-1:0]   count
);

    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(ENTRIES);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] r_busy;
    logic [ENTRIES-1:0] r_v0;
    logic [ENTRIES-1:0] r_v1;
    logic [INSTR_W-1:0] r_instr [ENTRIES];
    logic [TAG_W-1:0]   r_dst   [ENTRIES];
    logic [TAG_W-1:0]   r_t0    [ENTRIES];
    logic [TAG_W-1:0]   r_t1    [ENTRIES];
    logic [DATA_W-1:0]  r_d0    [ENTRIES];
    logic [DATA_W-1:0]  r_d1    [ENTRIES];
    // Age matrix: r_older[i][j] = 1 means entry i was allocated before
    // entry j. A new entry clears its own row (younger than everyone) and
    // sets its column in every other row. Relative order among existing
    // entries is untouched, so the busy entries always form a total order.
    logic [ENTRIES-1:0] r_older [ENTRIES];
    logic [CNT_W-1:0]   r_count;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] w_hit0;
    logic [ENTRIES-1:0] w_hit1;
    logic [ENTRIES-1:0] w_rdy;
    logic [ENTRIES-1:0] w_sel;
    logic [ENTRIES-1:0] w_alloc_oh;
    logic               w_alloc_found;
    logic               w_alloc_fire;
    logic               w_issue_fire;

    // Wakeup match: only busy entries still waiting on an operand compare,
    // so stale tags in free entries can never capture.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_hit0[i] = r_busy[i] && !r_v0[i] && cdb_valid && (r_t0[i] == cdb_tag);
            w_hit1[i] = r_busy[i] && !r_v1[i] && cdb_valid && (r_t1[i] == cdb_tag);
`ifdef RS_FAST_WAKEUP_EN
            w_rdy[i]  = r_busy[i] && (r_v0[i] || w_hit0[i]) && (r_v1[i] || w_hit1[i]);
`else
            w_rdy[i]  = r_busy[i] && r_v0[i] && r_v1[i];
`endif
        end
    end

    // Oldest-ready select: an entry wins when no other ready entry is older.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_sel[i] = w_rdy[i];
            for (int j = 0; j < ENTRIES; j++) begin
                if (j != i && w_rdy[j] && r_older[j][i]) begin
                    w_sel[i] = 1'b0;
                end
            end
        end
    end

    // Lowest-index free entry for allocation.
    always_comb begin
        w_alloc_oh    = '0;
        w_alloc_found = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!r_busy[i] && !w_alloc_found) begin
                w_alloc_oh[i] = 1'b1;
                w_alloc_found = 1'b1;
            end
        end
    end

    // Payload outputs are zero whenever nothing is selected.
    always_comb begin
        issue_instr = '0;
        issue_tag   = '0;
        issue_d0    = '0;
        issue_d1    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_sel[i]) begin
                issue_instr = r_instr[i];
                issue_tag   = r_dst[i];
`ifdef RS_FAST_WAKEUP_EN
                issue_d0    = r_v0[i] ? r_d0[i] : cdb_data;
                issue_d1    = r_v1[i] ? r_d1[i] : cdb_data;
`else
                issue_d0    = r_d0[i];
                issue_d1    = r_d1[i];
`endif
            end
        end
    end

    // alloc_ready looks only at the registered count, so a full station
    // does not accept even when an issue frees an entry in the same cycle.
    assign alloc_ready  = (r_count != c_FULL);
    assign issue_valid  = |w_rdy;
    assign w_alloc_fire = alloc_valid && alloc_ready;
    assign w_issue_fire = issue_valid && issue_ready;
    assign count        = r_count;

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_busy  <= '0;
            r_v0    <= '0;
            r_v1    <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_issue_fire && w_sel[i]) begin
                    // Issued entry is freed; any same-cycle wakeup is moot.
                    r_busy[i] <= 1'b0;
                    r_v0[i]   <= 1'b0;
                    r_v1[i]   <= 1'b0;
                end else if (w_alloc_fire && w_alloc_oh[i]) begin
                    r_busy[i]  <= 1'b1;
                    r_instr[i] <= alloc_instr;
                    r_dst[i]   <= alloc_tag;
                    r_t0[i]    <= src0_tag;
                    r_t1[i]    <= src1_tag;
                    // Source data first, then allocation-time CDB bypass.
                    if (src0_rdy) begin
                        r_d0[i] <= src0_data;
                        r_v0[i] <= 1'b1;
                    end else if (cdb_valid && cdb_tag == src0_tag) begin
                        r_d0[i] <= cdb_data;
                        r_v0[i] <= 1'b1;
                    end else begin
                        r_v0[i] <= 1'b0;
                    end
                    if (src1_rdy) begin
                        r_d1[i] <= src1_data;
                        r_v1[i] <= 1'b1;
                    end else if (cdb_valid && cdb_tag == src1_tag) begin
                        r_d1[i] <= cdb_data;
                        r_v1[i] <= 1'b1;
                    end else begin
                        r_v1[i] <= 1'b0;
                    end
                end else begin
                    if (w_hit0[i]) begin
                        r_d0[i] <= cdb_data;
                        r_v0[i] <= 1'b1;
                    end
                    if (w_hit1[i]) begin
                        r_d1[i] <= cdb_data;
                        r_v1[i] <= 1'b1;
                    end
                end
            end

            case ({w_alloc_fire, w_issue_fire})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Age matrix only matters for busy entries, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!(rst || flush) && w_alloc_fire) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (w_alloc_oh[j]) begin
                    r_older[j] <= '0;
                end else begin
                    r_older[j] <= r_older[j] | w_alloc_oh;
                end
            end
        end
    end

endmodule
`default_nettype wire
